// File: rtl/random_access_memory.sv
// rtl/random_access_memory.sv - 16x8 RAM with bus and manual write paths and a zero-fill sweep
// The sweep also runs automatically after reset, so the array never needs its own reset.
module random_access_memory (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] address,
  input  logic [7:0] bus_in,
  input  logic       write_from_bus,
  input  logic       out_to_bus,
  input  logic       manual_mode,
  input  logic       manual_write,
  input  logic [7:0] manual_switches,
  input  logic       clear_request,
  output logic [7:0] bus_out,
  output logic       bus_out_en,
  output logic [7:0] data,
  output logic       busy
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       sync1_q, sync2_q, sync2_prev_q;
  logic [7:0] data_q;
  logic [7:0] mem_q [16];

  logic       mem_we;
  logic [3:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic       manual_pulse;

  assign manual_pulse = sync2_q & ~sync2_prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= CLEAR;
      cnt_q        <= 4'd0;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      sync2_prev_q <= 1'b0;
      data_q       <= 8'h00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sync1_q      <= manual_write;
      sync2_q      <= sync1_q;
      sync2_prev_q <= sync2_q;
      data_q       <= mem_q[address];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = address;
    mem_wdata = bus_in;
    case (state_q)
      IDLE: begin
        // A clear request wins over any write presented in the same cycle.
        if (clear_request) begin
          state_d = CLEAR;
          cnt_d   = 4'd0;
        end else if (manual_mode) begin
          if (manual_pulse) begin
            mem_we    = 1'b1;
            mem_wdata = manual_switches;
          end
        end else if (write_from_bus) begin
          mem_we = 1'b1;
        end
      end
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = 8'h00;
        cnt_d     = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Reset holds the FSM in CLEAR, so the write strobe must also be gated by rst.
  always_ff @(posedge clk) begin
    if (rst && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign bus_out    = mem_q[address];
  assign bus_out_en = out_to_bus & ~manual_mode & (state_q == IDLE);
  assign data       = data_q;
  assign busy       = (state_q == CLEAR);

endmodule

// File: tb/tb_random_access_memory.sv
// tb/tb_random_access_memory.sv - directed self-checking bench for random_access_memory
module tb_random_access_memory;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] address;
  logic [7:0] bus_in;
  logic       write_from_bus;
  logic       out_to_bus;
  logic       manual_mode;
  logic       manual_write;
  logic [7:0] manual_switches;
  logic       clear_request;
  logic [7:0] bus_out;
  logic       bus_out_en;
  logic [7:0] data;
  logic       busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  random_access_memory dut (
    .clk             (clk),
    .rst             (rst),
    .address         (address),
    .bus_in          (bus_in),
    .write_from_bus  (write_from_bus),
    .out_to_bus      (out_to_bus),
    .manual_mode     (manual_mode),
    .manual_write    (manual_write),
    .manual_switches (manual_switches),
    .clear_request   (clear_request),
    .bus_out         (bus_out),
    .bus_out_en      (bus_out_en),
    .data            (data),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    int n;
    rst = 1'b1; address = 4'd0; bus_in = 8'h00; write_from_bus = 1'b0; out_to_bus = 1'b1;
    manual_mode = 1'b0; manual_write = 1'b0; manual_switches = 8'h00; clear_request = 1'b0;
    #2 rst = 1'b0;
    #1;
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL reset_busy got=%b exp=1", busy); else pass_cnt++;
    total_cnt++;
    if (bus_out_en !== 1'b0) $display("FAIL reset_bus_out_en got=%b exp=0", bus_out_en); else pass_cnt++;
    total_cnt++;
    if (data !== 8'h00) $display("FAIL reset_data got=%h exp=00", data); else pass_cnt++;
    tick; tick;
    @(negedge clk);
    rst = 1'b1;
    out_to_bus = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      tick;
      n++;
    end
    total_cnt++;
    if (n !== 16) $display("FAIL reset_sweep_len got=%0d exp=16", n); else pass_cnt++;
    for (int a = 0; a < 16; a++) begin
      address = a[3:0];
      tick;
      total_cnt++;
      if (data !== 8'h00) $display("FAIL reset_data_word%0d got=%h exp=00", a, data); else pass_cnt++;
    end
  endtask

  task automatic test_bus_write;
    address = 4'h3; bus_in = 8'hA5; write_from_bus = 1'b1; out_to_bus = 1'b0;
    tick;
    write_from_bus = 1'b0; out_to_bus = 1'b1;
    #1;
    total_cnt++;
    if (bus_out_en !== 1'b1) $display("FAIL bus_rd_en got=%b exp=1", bus_out_en); else pass_cnt++;
    total_cnt++;
    if (bus_out !== 8'hA5) $display("FAIL bus_rd_data got=%h exp=a5", bus_out); else pass_cnt++;
    total_cnt++;
    if (data !== 8'h00) $display("FAIL bus_data_prewrite got=%h exp=00", data); else pass_cnt++;
    tick;
    total_cnt++;
    if (data !== 8'hA5) $display("FAIL bus_data_latency got=%h exp=a5", data); else pass_cnt++;
    out_to_bus = 1'b0;
  endtask

  task automatic test_manual_write;
    manual_mode = 1'b1; address = 4'h7; manual_switches = 8'h3C; manual_write = 1'b1;
    out_to_bus = 1'b1;
    #1;
    total_cnt++;
    if (bus_out_en !== 1'b0) $display("FAIL man_bus_en_blocked got=%b exp=0", bus_out_en); else pass_cnt++;
    tick;
    total_cnt++;
    if (bus_out !== 8'h00) $display("FAIL man_edge_n got=%h exp=00", bus_out); else pass_cnt++;
    tick;
    total_cnt++;
    if (bus_out !== 8'h00) $display("FAIL man_edge_n1 got=%h exp=00", bus_out); else pass_cnt++;
    tick;
    total_cnt++;
    if (bus_out !== 8'h3C) $display("FAIL man_edge_n2 got=%h exp=3c", bus_out); else pass_cnt++;
    manual_switches = 8'h55; bus_in = 8'h99;
    for (int i = 0; i < 17; i++) begin
      write_from_bus = i[0];
      tick;
    end
    write_from_bus = 1'b0;
    total_cnt++;
    if (bus_out !== 8'h3C) $display("FAIL man_held_once got=%h exp=3c", bus_out); else pass_cnt++;
    manual_write = 1'b0;
    tick; tick; tick;
    manual_write = 1'b1;
    tick; tick; tick;
    total_cnt++;
    if (bus_out !== 8'h55) $display("FAIL man_repress got=%h exp=55", bus_out); else pass_cnt++;
    manual_write = 1'b0;
    tick; tick; tick;
    manual_mode = 1'b0; manual_switches = 8'hAA; manual_write = 1'b1;
    tick; tick; tick; tick;
    manual_mode = 1'b1;
    tick; tick; tick;
    total_cnt++;
    if (bus_out !== 8'h55) $display("FAIL man_pulse_discard got=%h exp=55", bus_out); else pass_cnt++;
    manual_write = 1'b0; manual_mode = 1'b0; out_to_bus = 1'b0;
    tick; tick; tick;
  endtask

  task automatic test_clear;
    int n;
    for (int a = 0; a < 16; a++) begin
      address = a[3:0]; bus_in = 8'hFF; write_from_bus = 1'b1;
      tick;
    end
    address = 4'h2; bus_in = 8'h11; write_from_bus = 1'b1; clear_request = 1'b1;
    tick;
    clear_request = 1'b0; write_from_bus = 1'b0;
    #1;
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL clr_busy_start got=%b exp=1", busy); else pass_cnt++;
    total_cnt++;
    if (bus_out !== 8'hFF) $display("FAIL clr_write_dropped got=%h exp=ff", bus_out); else pass_cnt++;
    n = 1;
    tick;
    while (busy && n < 40) begin
      clear_request = (n == 5);
      tick;
      n++;
    end
    clear_request = 1'b0;
    total_cnt++;
    if (n !== 16) $display("FAIL clr_sweep_len got=%0d exp=16", n); else pass_cnt++;
    for (int a = 0; a < 16; a++) begin
      address = a[3:0];
      #1;
      total_cnt++;
      if (bus_out !== 8'h00) $display("FAIL clr_word%0d got=%h exp=00", a, bus_out); else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_sweep;
    int n;
    address = 4'hC; bus_in = 8'hEE; write_from_bus = 1'b1;
    tick;
    write_from_bus = 1'b0;
    tick;
    clear_request = 1'b1;
    tick;
    clear_request = 1'b0;
    for (int i = 0; i < 8; i++) tick;
    total_cnt++;
    if (data !== 8'hEE) $display("FAIL rst_mid_data_before got=%h exp=ee", data); else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++;
    if (data !== 8'h00) $display("FAIL rst_mid_data_async got=%h exp=00", data); else pass_cnt++;
    out_to_bus = 1'b1;
    #1;
    total_cnt++;
    if (bus_out_en !== 1'b0) $display("FAIL rst_mid_bus_en got=%b exp=0", bus_out_en); else pass_cnt++;
    out_to_bus = 1'b0;
    tick; tick;
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    while (busy && n < 40) begin
      tick;
      n++;
    end
    total_cnt++;
    if (n !== 16) $display("FAIL rst_mid_sweep_len got=%0d exp=16", n); else pass_cnt++;
    total_cnt++;
    if (bus_out !== 8'h00) $display("FAIL rst_mid_word12 got=%h exp=00", bus_out); else pass_cnt++;
  endtask

  task automatic test_same_cycle;
    address = 4'h9; bus_in = 8'h01; write_from_bus = 1'b1;
    tick;
    bus_in = 8'h5A; out_to_bus = 1'b1;
    #1;
    total_cnt++;
    if (bus_out !== 8'h01) $display("FAIL same_cyc_pre got=%h exp=01", bus_out); else pass_cnt++;
    total_cnt++;
    if (bus_out_en !== 1'b1) $display("FAIL same_cyc_en got=%b exp=1", bus_out_en); else pass_cnt++;
    tick;
    write_from_bus = 1'b0;
    #1;
    total_cnt++;
    if (bus_out !== 8'h5A) $display("FAIL same_cyc_post got=%h exp=5a", bus_out); else pass_cnt++;
    out_to_bus = 1'b0;
  endtask

  initial begin
    test_reset;
    test_bus_write;
    test_manual_write;
    test_clear;
    test_reset_mid_sweep;
    test_same_cycle;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
